// File: rtl/cache_fill_fsm.sv
// Block-fill controller between a cache and pipelined main memory.
// Streams one block of words in, then writes the tag; stalls the CPU meanwhile.
module cache_fill_fsm #(
  parameter int ADDR_W          = 16,
  parameter int WORDS_PER_BLOCK = 8,
  parameter int OFF_W           = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              memory_data_valid,
  output logic              fsm_busy,
  output logic              mem_read_en,
  output logic [ADDR_W-1:0] memory_address,
  output logic              write_data_array,
  output logic [OFF_W-1:0]  word_offset,
  output logic              write_tag_array
);

  typedef enum logic {
    IDLE,
    FILL
  } state_t;

  localparam logic [ADDR_W-1:0] LOW_MASK =
    ADDR_W'((1 << (OFF_W + 1)) - 1);
  localparam logic [OFF_W-1:0] LAST_OFF =
    OFF_W'(WORDS_PER_BLOCK - 1);

  state_t            state;
  logic [OFF_W:0]    iss;
  logic [OFF_W-1:0]  ret;
  logic [ADDR_W-1:0] base;

  logic issuing;
  logic ret_hit;
  logic ret_last;

  // iss MSB set means every word of the block has been requested
  assign issuing  = (state == FILL) && !iss[OFF_W];
  assign ret_hit  = (state == FILL) && memory_data_valid;
  assign ret_last = ret_hit && (ret == LAST_OFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      iss   <= '0;
      ret   <= '0;
      base  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          iss <= '0;
          ret <= '0;
          if (miss_detected) begin
            base  <= miss_address & ~LOW_MASK;
            state <= FILL;
          end
        end
        FILL: begin
          if (issuing)
            iss <= iss + 1'b1;
          if (ret_hit)
            ret <= ret + 1'b1;
          if (ret_last) begin
            state <= IDLE;
            iss   <= '0;
            ret   <= '0;
          end
        end
      endcase
    end
  end

  // Stall must reach the CPU in the very cycle the miss is seen
  assign fsm_busy = rst_n &&
    ((state == FILL) || miss_detected);

  assign mem_read_en = issuing;

  // Base has its offset bits cleared, so OR-ing never carries into the tag
  assign memory_address = issuing ?
    (base | ADDR_W'({iss[OFF_W-1:0], 1'b0})) :
    '0;

  assign write_data_array = ret_hit;
  assign word_offset      = ret_hit ? ret : '0;
  assign write_tag_array  = ret_last;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Scoreboard bench for cache_fill_fsm.
// A latency-modelled memory answers reads; a monitor checks every output.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        memory_data_valid;
  logic        fsm_busy;
  logic        mem_read_en;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [2:0]  word_offset;
  logic        write_tag_array;

  cache_fill_fsm #(
    .ADDR_W(16),
    .WORDS_PER_BLOCK(8),
    .OFF_W(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .miss_detected(miss_detected),
    .miss_address(miss_address),
    .memory_data_valid(memory_data_valid),
    .fsm_busy(fsm_busy),
    .mem_read_en(mem_read_en),
    .memory_address(memory_address),
    .write_data_array(write_data_array),
    .word_offset(word_offset),
    .write_tag_array(write_tag_array)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int errors = 0;
  int cyc    = 0;

  logic [15:0] exp_addr_q[$];
  logic [3:0]  exp_wr_q[$];
  int          exp_busy_q[$];
  int          pend_q[$];

  int lat         = 4;
  bit irregular   = 1'b0;
  int iss_n       = 0;
  int last_ret    = 0;
  bit force_valid = 1'b0;
  int busy_run    = 0;
  int lat_tab[8]  = '{1, 8, 3, 2, 6, 1, 5, 4};
  int l, t, e;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    tests++;
    errors++;
    $display("FAIL %s: got event expected none", name);
  endtask

  // Memory model: answers each read after its latency, in issue order
  initial begin
    memory_data_valid = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      if (!rst_n)
        pend_q.delete();
      if (pend_q.size() > 0 && pend_q[0] == cyc) begin
        void'(pend_q.pop_front());
        memory_data_valid = 1'b1;
      end else begin
        memory_data_valid = force_valid;
      end
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_outputs",
          int'({fsm_busy, mem_read_en, write_data_array,
                write_tag_array, memory_address, word_offset}), 0);
      last_ret = 0;
    end else begin
      if (mem_read_en) begin
        if (exp_addr_q.size() == 0)
          fail("extra_read");
        else
          chk("read_addr", int'(memory_address),
              int'(exp_addr_q.pop_front()));
        l = irregular ? lat_tab[iss_n % 8] : lat;
        iss_n++;
        t = cyc + l;
        if (t <= last_ret)
          t = last_ret + 1;
        last_ret = t;
        pend_q.push_back(t);
      end else begin
        chk("addr_idle_zero", int'(memory_address), 0);
      end
      if (write_data_array) begin
        if (exp_wr_q.size() == 0)
          fail("extra_write");
        else
          chk("write_tag_off", int'({write_tag_array, word_offset}),
              int'(exp_wr_q.pop_front()));
      end else begin
        chk("tag_without_write", int'(write_tag_array), 0);
        chk("offset_idle_zero", int'(word_offset), 0);
      end
    end
    if (fsm_busy) begin
      busy_run++;
    end else if (busy_run > 0) begin
      if (exp_busy_q.size() == 0) begin
        fail("extra_busy_run");
      end else begin
        e = exp_busy_q.pop_front();
        if (e >= 0)
          chk("busy_cycles", busy_run, e);
      end
      busy_run = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_fill(input logic [15:0] a);
    logic [15:0] b;
    b = a & 16'hFFF0;
    for (int i = 0; i < 8; i++) begin
      exp_addr_q.push_back(b + 16'(2 * i));
      exp_wr_q.push_back({(i == 7), 3'(i)});
    end
  endtask

  task automatic miss_once(input logic [15:0] a, input int busy);
    step();
    miss_detected = 1'b1;
    miss_address  = a;
    push_fill(a);
    exp_busy_q.push_back(busy);
    step();
    miss_detected = 1'b0;
    miss_address  = 16'h0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!fsm_busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done)
      fail("busy_timeout");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n         = 1'b0;
    miss_detected = 1'b0;
    miss_address  = 16'h0;
    repeat (3) step();
    rst_n = 1'b1;

    // Valid pulses while idle must not write
    repeat (2) step();
    for (int i = 0; i < 3; i++) begin
      force_valid = 1'b1;
      @(negedge clk);
      chk("idle_valid_no_write", int'(write_data_array), 0);
      chk("idle_not_busy", int'(fsm_busy), 0);
      step();
      force_valid = 1'b0;
    end

    miss_once(16'h1234, 13);
    wait_idle();

    miss_once(16'hFFFE, 13);
    wait_idle();

    // Miss during a fill is ignored, then re-presented
    miss_once(16'h0100, 13);
    repeat (2) step();
    miss_detected = 1'b1;
    miss_address  = 16'h0040;
    repeat (4) step();
    miss_detected = 1'b0;
    miss_address  = 16'h0;
    wait_idle();
    miss_once(16'h0040, 13);
    wait_idle();

    // Reset on fill cycle 6
    miss_once(16'h0A0A, 7);
    repeat (6) step();
    rst_n = 1'b0;
    repeat (2) step();
    chk("rst_left_reads", exp_addr_q.size(), 2);
    chk("rst_left_writes", exp_wr_q.size(), 6);
    exp_addr_q.delete();
    exp_wr_q.delete();
    rst_n = 1'b1;
    step();
    miss_once(16'h2468, 13);
    wait_idle();

    // Irregular latencies
    irregular = 1'b1;
    iss_n     = 0;
    miss_once(16'h5550, -1);
    wait_idle();
    irregular = 1'b0;

    // Miss held high: accepted on first idle cycle after the fill
    step();
    miss_detected = 1'b1;
    miss_address  = 16'h0200;
    push_fill(16'h0200);
    exp_busy_q.push_back(26);
    step();
    miss_address = 16'h0300;
    push_fill(16'h0300);
    repeat (13) step();
    miss_detected = 1'b0;
    miss_address  = 16'h0;
    wait_idle();

    repeat (5) step();
    chk("reads_drained", exp_addr_q.size(), 0);
    chk("writes_drained", exp_wr_q.size(), 0);
    chk("busy_drained", exp_busy_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
